// File: rtl/expr_string_gen.sv
// expr_string_gen: serializes a packed arithmetic expression (single-digit
// operands, '+'/'*' operators) as an ASCII character stream with a
// valid/ready handshake, one character per accepted beat.
// Optional macro EXPR_EVAL_EN adds an evaluator that reports the value of
// the expression, with '*' binding tighter than '+', once the last digit
// is accepted. When the macro is undefined, result/result_valid are tied
// to zero and no multiplier is built.
module expr_string_gen #(
  parameter int MAX_N = 8,
  parameter int RES_W = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [3:0]           len,
  input  logic [4*MAX_N-1:0]   digits,
  input  logic [MAX_N-2:0]     ops,
  output logic                 busy,
  output logic [7:0]           out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 err,
  output logic [RES_W-1:0]     result,
  output logic                 result_valid
);

  typedef enum logic [1:0] {IDLE, DIGIT, OP, DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [3:0]           lenm1_q, lenm1_d;
  logic [4*MAX_N-1:0]   dig_q, dig_d;   // shifts right as digits are consumed
  logic [MAX_N-2:0]     ops_q, ops_d;   // shifts right as operators are consumed
  logic                 busy_q, busy_d;
  logic [7:0]           out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 err_q, err_d;
`ifdef EXPR_EVAL_EN
  logic                 mul_q, mul_d;   // operator preceding the current digit
  logic [RES_W-1:0]     sum_q, sum_d;
  logic [RES_W-1:0]     prod_q, prod_d;
  logic [RES_W-1:0]     result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic [RES_W-1:0]     dv;
`endif

  logic hs;
  assign hs = out_valid_q & out_ready;

  // Illegal digits are sent as '0'.
  function automatic logic [7:0] dchar(input logic [3:0] d);
    return (d > 4'd9) ? 8'h30 : (8'h30 + {4'h0, d});
  endfunction

  // Next-state and next-output logic for the serializer FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lenm1_d     = lenm1_q;
    dig_d       = dig_q;
    ops_d       = ops_q;
    busy_d      = busy_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
`ifdef EXPR_EVAL_EN
    mul_d          = mul_q;
    sum_d          = sum_q;
    prod_d         = prod_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    dv             = RES_W'((dig_q[3:0] > 4'd9) ? 4'd0 : dig_q[3:0]);
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len < 4'd2 || len > 4'(MAX_N)) begin
            err_d = 1'b1;
          end else begin
            state_d     = DIGIT;
            idx_d       = 4'd0;
            lenm1_d     = len - 4'd1;
            dig_d       = digits;
            ops_d       = ops;
            busy_d      = 1'b1;
            out_d       = dchar(digits[3:0]);
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            err_d       = (digits[3:0] > 4'd9);
`ifdef EXPR_EVAL_EN
            mul_d    = 1'b0;
            sum_d    = '0;
            prod_d   = '0;
            result_d = '0;
`endif
          end
        end
      end
      DIGIT: begin
        if (hs) begin
`ifdef EXPR_EVAL_EN
          if (idx_q == 4'd0) begin
            prod_d = dv;
          end else if (mul_q) begin
            prod_d = prod_q * dv;
          end else begin
            sum_d  = sum_q + prod_q;
            prod_d = dv;
          end
`endif
          dig_d      = dig_q >> 4;
          out_last_d = 1'b0;
          if (idx_q == lenm1_q) begin
            state_d     = DONE;
            out_d       = 8'h00;
            out_valid_d = 1'b0;
`ifdef EXPR_EVAL_EN
            result_d       = sum_d + prod_d;
            result_valid_d = 1'b1;
`endif
          end else begin
            state_d = OP;
            out_d   = ops_q[0] ? 8'h2A : 8'h2B;
          end
        end
      end
      OP: begin
        if (hs) begin
`ifdef EXPR_EVAL_EN
          mul_d = ops_q[0];
`endif
          ops_d      = ops_q >> 1;
          idx_d      = idx_q + 4'd1;
          state_d    = DIGIT;
          out_d      = dchar(dig_q[3:0]);
          err_d      = (dig_q[3:0] > 4'd9);
          out_last_d = ((idx_q + 4'd1) == lenm1_q);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; clr clears everything immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lenm1_q     <= '0;
      dig_q       <= '0;
      ops_q       <= '0;
      busy_q      <= 1'b0;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef EXPR_EVAL_EN
      mul_q          <= 1'b0;
      sum_q          <= '0;
      prod_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lenm1_q     <= lenm1_d;
      dig_q       <= dig_d;
      ops_q       <= ops_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
`ifdef EXPR_EVAL_EN
      mul_q          <= mul_d;
      sum_q          <= sum_d;
      prod_q         <= prod_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
`ifdef EXPR_EVAL_EN
  assign result       = result_q;
  assign result_valid = result_valid_q;
`else
  assign result       = {RES_W{1'b0}};
  assign result_valid = 1'b0;
`endif

endmodule

// File: tb/tb_expr_string_gen.sv
// Directed testbench for expr_string_gen (MAX_N=8, RES_W=32).
module tb_expr_string_gen;
  localparam int MAX_N = 8;
  localparam int RES_W = 32;
`ifdef EXPR_EVAL_EN
  localparam bit EVAL = 1'b1;
`else
  localparam bit EVAL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic             start = 1'b0;
  logic             out_ready = 1'b1;
  logic [3:0]       len = 4'd0;
  logic [31:0]      digits = 32'd0;
  logic [6:0]       ops = 7'd0;
  logic             busy, out_valid, out_last, err, result_valid;
  logic [7:0]       out;
  logic [RES_W-1:0] result;

  int checks = 0;
  int errors = 0;

  expr_string_gen #(.MAX_N(MAX_N), .RES_W(RES_W)) dut (
    .clk(clk), .clr(clr), .start(start), .len(len), .digits(digits), .ops(ops),
    .busy(busy), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .err(err), .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle, then scramble the request inputs.
  task automatic req(input logic [3:0] l, input logic [31:0] d, input logic [6:0] o);
    start = 1'b1; len = l; digits = d; ops = o;
    tick();
    start = 1'b0; len = 4'hF; digits = '1; ops = '1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, out_valid, out_last, err, result_valid, out, result} !== '0)
      begin errors++; $display("FAIL reset_async: got busy=%b v=%b last=%b err=%b rv=%b out=%h res=%0d, want all 0", busy, out_valid, out_last, err, result_valid, out, result); end
    start = 1'b1; len = 4'd3; digits = 32'h321;
    tick(); tick();
    start = 1'b0;
    clr = 1'b0;
    tick();
    checks++;
    if ({busy, out_valid, out_last, err, result_valid, out, result} !== '0)
      begin errors++; $display("FAIL reset_release: got busy=%b v=%b out=%h err=%b, want all 0", busy, out_valid, out, err); end
  endtask

  task automatic test_basic();
    logic [7:0]  ec [5] = '{8'h31, 8'h2B, 8'h32, 8'h2A, 8'h33};
    logic [11:0] ev;
    out_ready = 1'b1;
    req(4'd3, 32'h321, 7'b0000010);
    for (int i = 0; i < 5; i++) begin
      ev = {1'b1, 1'b1, (i == 4), 1'b0, ec[i]};
      checks++;
      if ({busy, out_valid, out_last, err, out} !== ev)
        begin errors++; $display("FAIL basic_char%0d: got {busy,v,last,err,out}=%h, want %h", i, {busy, out_valid, out_last, err, out}, ev); end
      tick();
    end
    checks++;
    if ({busy, out_valid, out_last, result_valid} !== {3'b100, EVAL} || result !== (EVAL ? 32'd7 : 32'd0))
      begin errors++; $display("FAIL basic_done: got busy=%b v=%b rv=%b res=%0d, want busy=1 v=0 rv=%b res=%0d", busy, out_valid, result_valid, result, EVAL, EVAL ? 7 : 0); end
    tick();
    checks++;
    if ({busy, out_valid, result_valid} !== 3'b000 || result !== (EVAL ? 32'd7 : 32'd0))
      begin errors++; $display("FAIL basic_idle: got busy=%b v=%b rv=%b res=%0d, want 0 0 0 res=%0d", busy, out_valid, result_valid, result, EVAL ? 7 : 0); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  ec [3] = '{8'h32, 8'h2A, 8'h33};
    logic [11:0] ev;
    out_ready = 1'b1;
    req(4'd3, 32'h321, 7'b0000010);
    checks++;
    if ({busy, out_valid, out_last, err, out} !== 12'hC31)
      begin errors++; $display("FAIL bp_char0: got %h, want c31", {busy, out_valid, out_last, err, out}); end
    tick();
    out_ready = 1'b0;
    start = 1'b1; len = 4'd1; digits = 32'h0;   // ignored while busy, no err
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({busy, out_valid, out_last, err, out} !== 12'hC2B)
        begin errors++; $display("FAIL bp_hold%0d: got %h, want c2b", k, {busy, out_valid, out_last, err, out}); end
    end
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ev = {1'b1, 1'b1, (i == 2), 1'b0, ec[i]};
      checks++;
      if ({busy, out_valid, out_last, err, out} !== ev)
        begin errors++; $display("FAIL bp_resume%0d: got %h, want %h", i, {busy, out_valid, out_last, err, out}, ev); end
    end
    tick();
    checks++;
    if ({busy, out_valid, result_valid} !== {2'b10, EVAL} || result !== (EVAL ? 32'd7 : 32'd0))
      begin errors++; $display("FAIL bp_done: got busy=%b v=%b rv=%b res=%0d", busy, out_valid, result_valid, result); end
    tick();
  endtask

  task automatic test_bad_len();
    logic [3:0] bl [3] = '{4'd1, 4'd9, 4'd0};
    for (int i = 0; i < 3; i++) begin
      req(bl[i], 32'h1111_1111, 7'h0);
      checks++;
      if ({busy, out_valid, err} !== 3'b001)
        begin errors++; $display("FAIL badlen%0d_pulse: got busy=%b v=%b err=%b, want 0 0 1", bl[i], busy, out_valid, err); end
      tick();
      checks++;
      if ({busy, out_valid, err} !== 3'b000)
        begin errors++; $display("FAIL badlen%0d_after: got busy=%b v=%b err=%b, want 0 0 0", bl[i], busy, out_valid, err); end
    end
  endtask

  task automatic test_illegal_digit();
    logic [7:0]  ec [3] = '{8'h34, 8'h2B, 8'h30};
    logic [11:0] ev;
    req(4'd2, 32'hC4, 7'h0);
    for (int i = 0; i < 3; i++) begin
      ev = {1'b1, 1'b1, (i == 2), (i == 2), ec[i]};
      checks++;
      if ({busy, out_valid, out_last, err, out} !== ev)
        begin errors++; $display("FAIL illegal_char%0d: got %h, want %h", i, {busy, out_valid, out_last, err, out}, ev); end
      tick();
    end
    checks++;
    if ({busy, out_valid, err, result_valid} !== {3'b100, EVAL} || result !== (EVAL ? 32'd4 : 32'd0))
      begin errors++; $display("FAIL illegal_done: got busy=%b v=%b err=%b rv=%b res=%0d, want res=%0d", busy, out_valid, err, result_valid, result, EVAL ? 4 : 0); end
    tick();
  endtask

  task automatic test_clr_restart();
    logic [7:0]  ec [3] = '{8'h39, 8'h2A, 8'h39};
    logic [11:0] ev;
    req(4'd3, 32'h321, 7'b0000010);
    tick();
    #2 clr = 1'b1;
    #1;
    checks++;
    if ({busy, out_valid, out_last, err, result_valid, out, result} !== '0)
      begin errors++; $display("FAIL clr_async: got busy=%b v=%b out=%h res=%0d, want all 0", busy, out_valid, out, result); end
    @(negedge clk) clr = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, out_valid, out_last, result_valid} !== 4'b0000)
      begin errors++; $display("FAIL clr_quiet: got busy=%b v=%b last=%b rv=%b, want 0", busy, out_valid, out_last, result_valid); end
    req(4'd2, 32'h99, 7'b0000001);
    for (int i = 0; i < 3; i++) begin
      ev = {1'b1, 1'b1, (i == 2), 1'b0, ec[i]};
      checks++;
      if ({busy, out_valid, out_last, err, out} !== ev)
        begin errors++; $display("FAIL restart_char%0d: got %h, want %h", i, {busy, out_valid, out_last, err, out}, ev); end
      tick();
    end
    checks++;
    if ({out_valid, result_valid} !== {1'b0, EVAL} || result !== (EVAL ? 32'd81 : 32'd0))
      begin errors++; $display("FAIL restart_done: got v=%b rv=%b res=%0d, want res=%0d", out_valid, result_valid, result, EVAL ? 81 : 0); end
    tick();
  endtask

  task automatic test_back_to_back_long();
    logic [11:0] ev;
    req(4'd8, 32'h9999_9999, 7'h7F);
    for (int i = 0; i < 15; i++) begin
      ev = {1'b1, 1'b1, (i == 14), 1'b0, (i % 2 == 0) ? 8'h39 : 8'h2A};
      checks++;
      if ({busy, out_valid, out_last, err, out} !== ev)
        begin errors++; $display("FAIL long_char%0d: got %h, want %h", i, {busy, out_valid, out_last, err, out}, ev); end
      if (i == 14) begin start = 1'b1; len = 4'd2; digits = 32'h11; ops = 7'h0; end
      tick();
    end
    checks++;
    if ({busy, out_valid, err, result_valid} !== {3'b100, EVAL} || result !== (EVAL ? 32'd43046721 : 32'd0))
      begin errors++; $display("FAIL long_done: got busy=%b v=%b err=%b rv=%b res=%0d, want res=%0d", busy, out_valid, err, result_valid, result, EVAL ? 43046721 : 0); end
    start = 1'b0;
    tick();
    checks++;
    if ({busy, out_valid, err, result_valid} !== 4'b0000)
      begin errors++; $display("FAIL long_start_ignored: got busy=%b v=%b err=%b rv=%b, want 0", busy, out_valid, err, result_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bad_len();
    test_illegal_digit();
    test_clr_restart();
    test_back_to_back_long();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
